i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h48, 7-bit bus address this target answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on scl_pin/sda_pin (min 2).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl_pin  input  1  I2C clock from master (no clock stretching).
REQ-006 sda_pin  inout  1  I2C data, open-drain: driven 0 or high-Z only, never driven 1.
REQ-007 reg_addr  output  8  current register pointer.
REQ-008 reg_wdata  output  8  byte received from master.
REQ-009 reg_we  output  1  one-clk pulse: write reg_wdata to reg_addr.
REQ-010 reg_re  output  1  one-clk pulse: request byte at reg_addr.
REQ-011 reg_rdata  input  8  read data, valid exactly 1 clk after reg_re.
REQ-012 busy  output  1  high from addressed START until STOP/NACK/mismatch.

Function
REQ-013 SHALL sample scl_pin/sda_pin through SYNC_STAGES flops; edges detected on synchronized values only.
REQ-014 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while SCL high.
REQ-015 Data bits SHALL be sampled on SCL rising edge, MSB first; SDA output changes only on SCL falling edge.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-017 IDLE->ADDR on START; any state->ADDR on START (repeated start); any state->IDLE on STOP.
REQ-018 ADDR: after 8 bits, if bits[7:1]==SLAVE_ADDR -> ADDR_ACK, else IDLE with SDA released.
REQ-019 ADDR_ACK: pull SDA low from 8th-bit SCL fall to 9th-bit SCL fall; then PTR if R/W=0, RD if R/W=1.
REQ-020 PTR: first write byte loads reg_addr; ACK via PTR_ACK; then WR.
REQ-021 WR: each further byte -> reg_wdata, reg_we pulses 1 clk at 8th SCL rising edge; WR_ACK acks; reg_addr increments after the pulse.
REQ-022 Read: reg_re pulses on the 9th-bit SCL fall of ADDR_ACK/RD_ACK; reg_rdata latched next clk into tx shift reg; first bit driven before next SCL rise.
REQ-023 RD_ACK: release SDA, sample master ACK on 9th SCL rise; ACK(0) -> increment reg_addr, RD; NACK(1) -> IDLE.
REQ-024 reg_addr SHALL wrap 8'hFF->8'h00; persists across transactions.
REQ-025 In RD, bits of value 1 SHALL be high-Z; SDA released in IDLE and on every STOP/START.
REQ-026 START/STOP mid-byte SHALL abort the byte: no reg_we, no pointer change.
REQ-027 Master NACK of address phase (mismatch) SHALL produce no reg_we/reg_re.

Reset
REQ-028 On reset: state IDLE, SDA high-Z, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, synchronizers=1 (bus idle).
REQ-029 Reset mid-transaction SHALL release SDA within 1 clk and ignore bus until next START.

Structure
REQ-030 Shared package i2c_pkg SHALL hold state enum, ACK=1'b0/NACK=1'b1 constants, R/W bit encoding, shared with i2c_master.
REQ-031 Sub-module i2c_sync_edge (synchronizer + SCL rise/fall, START/STOP detect) SHALL be instantiated once.
REQ-032 Bit counter 4 bits; rx/tx shift registers 8 bits each.

Verification
REQ-033 Write 0x48/W, ptr 0x10, data 0xA5 -> three ACKs; reg_we once, reg_addr=0x10, reg_wdata=0xA5; reg_addr=0x11 after.
REQ-034 Write ptr 0xFF, data 0x01,0x02 -> reg_we at 0xFF then 0x00.
REQ-035 Write ptr 0x20, repeated START, 0x48/R, master ACK then NACK -> reg_re at 0x20,0x21; SDA carries reg_rdata bytes; IDLE after NACK.
REQ-036 Address 0x49/W -> no ACK (SDA high 9th bit), busy=0, no reg_we.
REQ-037 STOP after 4 bits of data byte -> no reg_we, reg_addr unchanged, state IDLE.
REQ-038 Reset asserted during RD with SDA driven low -> SDA high-Z next clk, reg_addr=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C definitions for the slave and master
// Contents: FSM state enum, ACK/NACK bit values, R/W bit encoding, byte length.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - SCL/SDA synchronizer with edge and START/STOP detection
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   scl_in, sda_in   raw bus pins
//   sda              synchronized SDA level
//   scl_rise/fall    one-clk strobes on synchronized SCL edges
//   start/stop       one-clk strobes for bus START / STOP conditions
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;

    // Reset to all ones so the bus looks idle and no false edge is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    // SDA may only move while SCL is high for START/STOP, so require SCL high
    // on both sides of the SDA transition.
    assign start    = scl & scl_prev & sda_prev & ~sda;
    assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C register-access target with auto-incrementing pointer
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   scl_pin      bus clock from master (no stretching)
//   sda_pin      open-drain bus data (driven 0 or released)
//   reg_addr     register pointer; reg_wdata / reg_we write strobe
//   reg_re       read request; reg_rdata valid one clk after reg_re
//   busy         high while this target is addressed
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_pin,
    inout  wire        sda_pin,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    i2c_state_e state;
    logic [3:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic       rw;
    logic       sda_oe;
    logic       re_d;
    logic       master_ack;

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_pin),
        .sda_in   (sda_pin),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign sda_pin = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            rx_shift   <= 8'd0;
            tx_shift   <= 8'd0;
            rw         <= RW_WRITE;
            sda_oe     <= 1'b0;
            re_d       <= 1'b0;
            master_ack <= 1'b0;
            reg_addr   <= 8'd0;
            reg_wdata  <= 8'd0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            re_d   <= reg_re;
            // Pointer advances the clock after each write strobe.
            if (reg_we) begin
                reg_addr <= reg_addr + 8'd1;
            end

            if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    ADDR, PTR, WR: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[6:0], sda};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (state == WR && bit_cnt == BITS_PER_BYTE - 4'd1) begin
                                reg_wdata <= {rx_shift[6:0], sda};
                                reg_we    <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
                            if (state == ADDR) begin
                                if (rx_shift[7:1] == SLAVE_ADDR) begin
                                    state  <= ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    rw     <= rx_shift[0];
                                    busy   <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                reg_addr <= rx_shift;
                                sda_oe   <= 1'b1;
                                state    <= PTR_ACK;
                            end else begin
                                sda_oe <= 1'b1;
                                state  <= WR_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            if (rw == RW_READ) begin
                                state  <= RD;
                                reg_re <= 1'b1;
                            end else begin
                                state <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WR;
                        end
                    end
                    RD: begin
                        // re_d marks the clock reg_rdata is valid; it lands well
                        // inside the SCL low phase, before the next rise.
                        if (re_d) begin
                            tx_shift <= reg_rdata;
                            sda_oe   <= ~reg_rdata[7];
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == BITS_PER_BYTE) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sda_oe   <= ~tx_shift[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            master_ack <= (sda == ACK);
                            if (sda == ACK) begin
                                reg_addr <= reg_addr + 8'd1;
                            end
                        end else if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (master_ack) begin
                                state  <= RD;
                                reg_re <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - scoreboard testbench for i2c_slave
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'd0;
    logic       reg_we;
    logic       reg_re;
    logic       busy;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h48), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_pin   (scl),
        .sda_pin   (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr = 8'd0;
    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    logic [7:0]  wbuf [$];
    logic        preload = 1'b1;

    // Register file attached to the target: synchronous read like a RAM.
    logic [7:0] dev_mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= model_mem[i];
        end else begin
            if (reg_we) dev_mem[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= dev_mem[reg_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected register-port events whenever the DUT strobes.
    always @(negedge clk) begin
        if (!reset && !preload) begin
            if (reg_we) begin
                if (we_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected reg_we: addr %0h data %0h expected none", reg_addr, reg_wdata);
                end else begin
                    logic [15:0] e;
                    e = we_q.pop_front();
                    check("reg_we addr", reg_addr, e[15:8]);
                    check("reg_we data", reg_wdata, e[7:0]);
                end
            end
            if (reg_re) begin
                if (re_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected reg_re: addr %0h expected none", reg_addr);
                end else begin
                    logic [7:0] ea;
                    ea = re_q.pop_front();
                    check("reg_re addr", reg_addr, ea);
                end
            end
        end
    end

    task automatic wq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_low = ~b;
        wq();
        scl = 1'b1;
        wq();
        #1 r = sda;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wq();
        scl = 1'b1;   wq();
        m_low = 1'b1; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wq();
        scl = 1'b1;   wq();
        m_low = 1'b0; wq(); wq();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic d, a;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
        clock_bit(1'b1, a);
        check(name, a, exp_ack);
    endtask

    task automatic recv_byte(input logic ack_out, input logic [7:0] exp, input string name);
        logic [7:0] v;
        logic d;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, v[i]);
        clock_bit(ack_out, d);
        check(name, v, exp);
    endtask

    // Read n bytes from the current pointer; master ACKs all but the last.
    task automatic read_body(input int n);
        for (int i = 0; i < n; i++) re_q.push_back(model_ptr + 8'(i));
        send_byte({7'h48, RW_READ}, ACK, "read addr ack");
        check("busy while addressed", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                recv_byte(NACK, model_mem[model_ptr], "read data");
            end else begin
                recv_byte(ACK, model_mem[model_ptr], "read data");
                model_ptr++;
            end
        end
        i2c_stop();
        check("ptr after read", reg_addr, model_ptr);
        check("busy after read", busy, 1'b0);
    endtask

    task automatic txn_write(input logic [7:0] ptr);
        i2c_start();
        send_byte({7'h48, RW_WRITE}, ACK, "write addr ack");
        send_byte(ptr, ACK, "ptr ack");
        model_ptr = ptr;
        foreach (wbuf[i]) begin
            we_q.push_back({model_ptr, wbuf[i]});
            model_mem[model_ptr] = wbuf[i];
            model_ptr++;
            send_byte(wbuf[i], ACK, "data ack");
        end
        i2c_stop();
        check("ptr after write", reg_addr, model_ptr);
        check("busy after write", busy, 1'b0);
    endtask

    task automatic txn_ptr_read(input logic [7:0] ptr, input int n);
        i2c_start();
        send_byte({7'h48, RW_WRITE}, ACK, "write addr ack");
        send_byte(ptr, ACK, "ptr ack");
        model_ptr = ptr;
        i2c_start();
        read_body(n);
    endtask

    task automatic txn_cur_read(input int n);
        i2c_start();
        read_body(n);
    endtask

    task automatic txn_mismatch(input logic [6:0] a, input logic rw);
        i2c_start();
        send_byte({a, rw}, NACK, "mismatch nack");
        check("busy after mismatch", busy, 1'b0);
        i2c_stop();
        check("ptr after mismatch", reg_addr, model_ptr);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic d;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
        model_mem[8'h40] = 8'h3C;
        repeat (4) @(posedge clk);
        preload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset reg_addr", reg_addr, 8'h00);
        check("reset reg_wdata", reg_wdata, 8'h00);
        check("reset reg_we", reg_we, 1'b0);
        check("reset reg_re", reg_re, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset sda released", sda, 1'b1);
        reset = 1'b0;
        wq();

        // Single write: pointer 0x10, data 0xA5.
        wbuf = '{8'hA5};
        txn_write(8'h10);
        check("wdata held", reg_wdata, 8'hA5);

        // Pointer wrap 0xFF -> 0x00.
        wbuf = '{8'h01, 8'h02};
        txn_write(8'hFF);

        // Pointer set, repeated START, two-byte read.
        txn_ptr_read(8'h20, 2);

        // Wrong address.
        txn_mismatch(7'h49, RW_WRITE);

        // STOP after 4 bits of a data byte.
        i2c_start();
        send_byte({7'h48, RW_WRITE}, ACK, "write addr ack");
        send_byte(8'h30, ACK, "ptr ack");
        model_ptr = 8'h30;
        for (int i = 0; i < 4; i++) clock_bit(i[0], d);
        i2c_stop();
        check("ptr after abort", reg_addr, 8'h30);
        check("state after abort", dut.state, IDLE);

        // Reset while the target drives a 0 data bit.
        i2c_start();
        send_byte({7'h48, RW_WRITE}, ACK, "write addr ack");
        send_byte(8'h40, ACK, "ptr ack");
        model_ptr = 8'h40;
        i2c_start();
        re_q.push_back(8'h40);
        send_byte({7'h48, RW_READ}, ACK, "read addr ack");
        wq();
        #1 check("rd drives low", sda, 1'b0);
        @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("sda after reset", sda, 1'b1);
        check("ptr after reset", reg_addr, 8'h00);
        check("busy after reset", busy, 1'b0);
        reset = 1'b0;
        model_ptr = 8'h00;
        i2c_stop();
        txn_cur_read(1);

        // Randomized traffic.
        for (int t = 0; t < 20; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    int n;
                    n = $urandom_range(0, 3);
                    wbuf = {};
                    for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
                    txn_write(8'($urandom));
                end
                1: txn_ptr_read(8'($urandom), $urandom_range(1, 3));
                2: txn_cur_read($urandom_range(1, 3));
                default: begin
                    logic [6:0] a;
                    a = 7'($urandom_range(0, 127));
                    if (a == 7'h48) a = 7'h49;
                    txn_mismatch(a, 1'($urandom));
                end
            endcase
        end

        repeat (10) @(posedge clk);
        check("we queue drained", we_q.size(), 0);
        check("re queue drained", re_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
